vga_scan_out: RTL
=================

Name: vga_scan_out

Overview:
- Pixel-request initiator for the 640x480@60 display path, running on the 25 MHz pixel clock.
- Generates scan coordinates next_x/next_y for the pattern/sprite responders and samples their R_in/G_in/B_in answer.
- Aligns that answer with registered HS/VS/blank and drives the VGA DAC pins.
- Other end of the coordinate->colour interface the pattern blocks serve.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, HS pulse width (clocks)
H_BACK, 48, horizontal back porch (clocks)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, VS pulse width (lines)
V_BACK, 33, vertical back porch (lines)
PIX_LAT, 1, responder latency in clocks from next_x/next_y to valid R_in/G_in/B_in (1..4)

Ports:
CLOCK_25  in  1  pixel clock, single clock domain
reset  in  1  asynchronous, active-low reset
R_in  in  8  red answer for the coordinate issued PIX_LAT clocks earlier
G_in  in  8  green answer, same timing as R_in
B_in  in  8  blue answer, same timing as R_in
next_x  out  10  horizontal coordinate being requested, raw counter 0..799
next_y  out  10  vertical coordinate being requested, raw counter 0..524
req_active  out  1  1 when next_x<H_VISIBLE and next_y<V_VISIBLE
frame_start  out  1  one-clock pulse when next_x=0 and next_y=0
VGA_HS  out  1  horizontal sync, active low
VGA_VS  out  1  vertical sync, active low
VGA_BLANK_N  out  1  0 during blanking
VGA_SYNC_N  out  1  constant 1
VGA_R  out  8  red to DAC
VGA_G  out  8  green to DAC
VGA_B  out  8  blue to DAC
VGA_CLK  out  1  ~CLOCK_25, combinational

Behaviour:
- Counters h_cnt (10b) and v_cnt (10b); H_TOTAL=800, V_TOTAL=525 (sums of the parameters).
- Each clock, h_cnt increments. At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments. v_cnt wraps to 0 when both counters are at their maximum in the same clock.
- next_x=h_cnt and next_y=v_cnt as registers, so the counters are the outputs. Values remain valid in blanking; responders may decode them, e.g. y>450.
- req_active and frame_start are combinational from the counter registers.
- Raw timing is decoded from (h_cnt, v_cnt):
  - hs_raw=0 for H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
  - vs_raw=0 for v_cnt in 490..491, over whole lines.
  - act_raw=req_active.
- hs_raw, vs_raw and act_raw pass through a shift register of depth PIX_LAT, then one output register.
- The RGB path has one output register; it samples R_in/G_in/B_in when the delayed act is 1, else loads 0.
- Total latency from counter to pins is PIX_LAT+1 clocks for HS, VS, BLANK_N and RGB alike, so colour is never skewed against sync.
- VGA_BLANK_N equals the delayed act. RGB is forced to 0 whenever VGA_BLANK_N=0.
- Reset (reset=0, asynchronous):
  - h_cnt=0, v_cnt=0; all delay stages hold hs=1, vs=1, act=0.
  - VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_R/G/B=0.
  - frame_start=1 combinationally while the counters are at 0.0.
- Reset release mid-frame restarts a full frame from 0,0; no partial-frame state survives.
- The first clock edge after release advances h_cnt to 1.
- Arithmetic is unsigned 10-bit. No counter may reach 800 or 525; wrap is by compare, not overflow.
- The PIX_LAT range is enforced by elaboration-time check.

Decomposition:
- Shared package vga_pkg holds:
  - timing constants (H_*/V_* defaults, H_TOTAL, V_TOTAL);
  - coordinate width COORD_W=10;
  - colour width COLOR_W=8.
- One natural sub-module: vga_delay_line, a parameterised DEPTH x WIDTH shift register with asynchronous active-low reset and a per-bit reset value. It delays the {hs, vs, act} bundle.

Test Plan:
- Reset held 10 clocks, then released:
  - while held: VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, RGB=0, next_x=0, next_y=0;
  - after release: next_x=1 one clock later.
- Free run one line:
  - next_x sequences 0..799 and wraps;
  - VGA_HS low for exactly 96 clocks, first low at clock 656+PIX_LAT+1 after the h_cnt=0 clock;
  - period 800.
- Free run two frames:
  - frame_start pulses every 420000 clocks;
  - VGA_VS low for exactly 1600 clocks, starting with line 490 shifted by PIX_LAT+1.
- Responder model returns R_in=next_x[7:0] (delayed PIX_LAT), G_in=next_y[7:0], B_in=8'hA5:
  - VGA_R at pixel (x,y) equals x[7:0], G equals y[7:0], B equals A5 while BLANK_N=1;
  - all 0 at x=640..799 and y=480..524.
- R_in=G_in=B_in=8'hFF held constant:
  - BLANK_N high exactly 640 clocks per active line and 0 in the 45 blank lines;
  - RGB=FF only where BLANK_N=1.
- Assert reset asynchronously (between edges) at h_cnt=300, v_cnt=200:
  - outputs go to reset values immediately;
  - after release, counting restarts at 0,0 and the next VS falls 490 lines later.
- Repeat the RGB-alignment scenario with PIX_LAT=3; sync-to-colour alignment must be unchanged.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_pkg : 640x480@60 timing defaults and shared widths        Rev 1.0
// ----------------------------------------------------------------------------
package vga_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int COORD_W   = 10;
  localparam int COLOR_W   = 8;

endpackage
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_delay_line : DEPTH x WIDTH shift register, per-bit reset value  Rev 1.0
// ----------------------------------------------------------------------------
module vga_delay_line #(
  parameter int              DEPTH   = 1,
  parameter int              WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_scan_out.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_scan_out : scan counters, sync decode and RGB alignment to DAC  Rev 1.0
// ----------------------------------------------------------------------------
module vga_scan_out
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FRONT   = vga_pkg::H_FRONT,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BACK    = vga_pkg::H_BACK,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FRONT   = vga_pkg::V_FRONT,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BACK    = vga_pkg::V_BACK,
  parameter int PIX_LAT   = 1
) (
  input  logic               CLOCK_25,
  input  logic               reset,
  input  logic [COLOR_W-1:0] R_in,
  input  logic [COLOR_W-1:0] G_in,
  input  logic [COLOR_W-1:0] B_in,
  output logic [COORD_W-1:0] next_x,
  output logic [COORD_W-1:0] next_y,
  output logic               req_active,
  output logic               frame_start,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               VGA_BLANK_N,
  output logic               VGA_SYNC_N,
  output logic [COLOR_W-1:0] VGA_R,
  output logic [COLOR_W-1:0] VGA_G,
  output logic [COLOR_W-1:0] VGA_B,
  output logic               VGA_CLK
);

  localparam logic [COORD_W-1:0] c_H_VIS   = COORD_W'(H_VISIBLE);
  localparam logic [COORD_W-1:0] c_H_MAX   = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [COORD_W-1:0] c_HS_BEG  = COORD_W'(H_VISIBLE + H_FRONT);
  localparam logic [COORD_W-1:0] c_HS_END  = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [COORD_W-1:0] c_V_VIS   = COORD_W'(V_VISIBLE);
  localparam logic [COORD_W-1:0] c_V_MAX   = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [COORD_W-1:0] c_VS_BEG  = COORD_W'(V_VISIBLE + V_FRONT);
  localparam logic [COORD_W-1:0] c_VS_END  = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);

  generate
    if (PIX_LAT < 1 || PIX_LAT > 4) begin : g_pix_lat_check
      $error("vga_scan_out: PIX_LAT must be within 1..4");
    end
  endgenerate

  logic [COORD_W-1:0] r_h_cnt;
  logic [COORD_W-1:0] r_v_cnt;
  logic               w_h_last;
  logic               w_v_last;
  logic               w_hs_raw;
  logic               w_vs_raw;
  logic [2:0]         w_dly;

  assign w_h_last = (r_h_cnt == c_H_MAX);
  assign w_v_last = (r_v_cnt == c_V_MAX);

  // Wrap by compare so the counters never reach the line/frame totals.
  always_ff @(posedge CLOCK_25 or negedge reset) begin
    if (!reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  assign next_x      = r_h_cnt;
  assign next_y      = r_v_cnt;
  assign req_active  = (r_h_cnt < c_H_VIS) && (r_v_cnt < c_V_VIS);
  assign frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);

  assign w_hs_raw = !((r_h_cnt >= c_HS_BEG) && (r_h_cnt < c_HS_END));
  assign w_vs_raw = !((r_v_cnt >= c_VS_BEG) && (r_v_cnt < c_VS_END));

  // Timing is held back by the responder latency so it meets its colour.
  vga_delay_line #(
    .DEPTH   (PIX_LAT),
    .WIDTH   (3),
    .RST_VAL (3'b110)
  ) u_dly (
    .clk   (CLOCK_25),
    .rst_n (reset),
    .i_d   ({w_hs_raw, w_vs_raw, req_active}),
    .o_q   (w_dly)
  );

  always_ff @(posedge CLOCK_25 or negedge reset) begin
    if (!reset) begin
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
    end else begin
      VGA_HS      <= w_dly[2];
      VGA_VS      <= w_dly[1];
      VGA_BLANK_N <= w_dly[0];
      VGA_R       <= w_dly[0] ? R_in : '0;
      VGA_G       <= w_dly[0] ? G_in : '0;
      VGA_B       <= w_dly[0] ? B_in : '0;
    end
  end

  assign VGA_SYNC_N = 1'b1;
  assign VGA_CLK    = ~CLOCK_25;

endmodule
`default_nettype wire
